// File: rtl/logic_op_sequencer.sv
// Issue-and-collect stage for the 1-bit AND/OR/XOR/NOT logic unit.
// Ports: clk/rst, in_valid/in_ready/in_instr (instruction push),
//   alu_op/alu_i0/alu_i1/alu_res (logic unit), out_valid/out_ready/
//   out_data (packed result words), fifo_level (FIFO occupancy).
module logic_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int PACK  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_instr,
  output logic [1:0]               alu_op,
  output logic                     alu_i0,
  output logic                     alu_i1,
  input  logic                     alu_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PACK-1:0]          out_data,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PACK);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(PACK - 1);

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e state_q, state_d;

  logic [3:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PACK-1:0] data_q, data_d;

  logic       full;
  logic       empty;
  logic       push;
  logic       issue;
  logic       word_done;
  logic [3:0] head;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Full blocks a push even if the head pops on the same edge,
  // so in_ready never depends on out_ready.
  assign push = in_valid && !full;

  assign in_ready   = !full;
  assign out_data   = data_q;
  assign fifo_level = level_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (word_done) state_d = HOLD;
      HOLD:    if (out_ready) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (state_q == HOLD);
    issue     = (state_q == COLLECT) && !empty;
    alu_op    = 2'b00;
    alu_i0    = 1'b0;
    alu_i1    = 1'b0;
    if (issue) begin
      alu_op = head[3:2];
      alu_i0 = head[1];
      alu_i1 = head[0];
    end
  end

  // Datapath next-state
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    word_done = 1'b0;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (issue) begin
      rd_ptr_d       = rd_ptr_q + AW'(1);
      data_d[cnt_q]  = alu_res;
      word_done      = (cnt_q == CNT_LAST);
      cnt_d          = word_done ? '0 : cnt_q + CW'(1);
    end
    unique case ({push, issue})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: level_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_instr;
    end
  end

endmodule

// File: doc/logic_op_sequencer.md
# logic_op_sequencer

Issue-and-collect stage wrapped around the team's 2-bit-opcode, 1-bit logic unit (AND/OR/XOR/NOT). It buffers incoming 4-bit instructions in a small FIFO and issues one instruction per cycle to the logic unit. It shifts each returned result bit into a PACK-bit result word and hands completed words downstream over a valid/ready handshake. It sits directly upstream of the logic unit, driving its opcode and operand inputs, and also consumes the unit's output.

## Interface
- DEPTH, 4, instruction FIFO entries; power of two, ≥2
- PACK, 8, result bits per output word; ≥2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_instr valid
- in_ready  output  1  FIFO can accept; equals !full
- in_instr  input  4  {op[1:0], i0, i1}; op in [3:2], i0 in [1], i1 in [0]
- alu_op  output  2  opcode to logic unit: 00 AND, 01 OR, 10 XOR, 11 NOT (~i0)
- alu_i0  output  1  operand 0 to logic unit
- alu_i1  output  1  operand 1 to logic unit
- alu_res  input  1  combinational result from logic unit
- out_valid  output  1  out_data holds a complete word
- out_ready  input  1  downstream accepts word
- out_data  output  PACK  packed results; result k of the word in bit k (LSB first)
- fifo_level  output  clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Push: in_valid & in_ready at a clock edge writes in_instr at the tail. Push is blocked whenever full, including when a pop occurs in the same cycle.
- States: COLLECT, HOLD.
- COLLECT: issue = FIFO non-empty. While issuing, alu_* is driven combinationally from the FIFO head. At the edge, alu_res is written to out_data[count], the head is popped, and count is incremented.
  - When count reaches PACK, count clears and the state goes to HOLD.
- HOLD: out_valid=1 and there is no issue or pop. Pushes are still accepted.
  - When out_valid & out_ready, the state goes to COLLECT. out_data holds its value until overwritten bit by bit.
- When not issuing (FIFO empty or in HOLD), alu_op=00, alu_i0=0, alu_i1=0.
- Simultaneous push and issue: both take effect, and fifo_level is unchanged.
- FIFO pointers have log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a separate count (0..DEPTH).
- rst asserted at any time:
  - Takes effect immediately.
  - Empties the FIFO and discards any partial word.
  - Sets count=0 and state COLLECT.
  - All outputs go to reset values.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, fifo_level=0.
  - alu_op=00, alu_i0=0, alu_i1=0.
- Instruction pushed at edge t into an empty FIFO in COLLECT: presented on alu_* during cycle t..t+1 and captured at edge t+1.
- Result word: out_valid rises immediately after the edge that captures the PACK-th issue.
- Minimum word period is PACK+1 cycles: PACK issue cycles plus one HOLD cycle with out_ready=1.
- in_ready and fifo_level update only on clock edges or rst. in_ready has no combinational path from out_ready.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.

## Test plan
- Truth table:
  - Stimulus: push instr = 0..15 in order with out_ready=1, driving the logic unit from alu_*.
  - Required: word 0 = 8'hE8, word 1 = 8'h36; each out_valid is high for exactly 1 cycle.
- Backpressure:
  - Stimulus: out_ready=0, push 8 + DEPTH instructions.
  - Required: out_valid holds with out_data stable, fifo_level=4, in_ready=0, and the extra push is dropped.
  - Then raise out_ready: the next word completes from the buffered instructions.
- Throughput:
  - Stimulus: continuous in_valid=1 with all-OR instructions of 1,0, and out_ready=1.
  - Required: out_data=8'hFF every 9 cycles; fifo_level never exceeds DEPTH.
- Empty idle:
  - Stimulus: no pushes for 10 cycles after 3 issued instructions.
  - Required: alu_op=00, alu_i0=0, alu_i1=0; the partial word is retained.
  - Then 5 more NOT instructions with i0=0 complete the word: bits[7:3]=11111.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between edges) after 5 issues with 2 entries buffered.
  - Required: out_valid=0, out_data=0, fifo_level=0, in_ready=1 immediately.
  - Then 8 XOR instructions of 1,0 yield 8'hFF.
- Simultaneous push and pop:
  - Stimulus: at level 2, push on the same edge as an issue.
  - Required: level stays 2 and FIFO order is preserved across pointer wrap (push 12 distinct instructions and check the result bit order).
